mem_port_arbiter: RTL and testbench

Two-port arbiter fronting the CPU's single-port 32 x 8 data/instruction memory. It shares that memory between the CPU core (port A) and a host/program-loader port (port B). The arbiter serves exactly one access per clock, round-robin between the ports. A host lock gives the loader exclusive access while it writes a program image. The memory array lives inside this block; the core and loader reach it only through the two request ports.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for the two-port memory arbiter: CPU port A,
// host/loader port B, the host lock and the last-owner indication.
interface mem_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  // Port A (CPU core)
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  // Port B (host / program loader)
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  // Host exclusive lock and last-granted port
  logic          b_lock;
  logic          owner;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  b_lock,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output owner
  );

  // Requester side
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output b_lock,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a single-port DEPTH x DW memory between the
// CPU (port A) and a host loader (port B). One access per clock; the host
// lock shuts port A out while a program image is written.
module mem_port_arbiter #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic                clk,
  input  logic                reset,   // asynchronous, active low
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  logic [DW-1:0] mem_q [DEPTH];

  port_e         owner_q, owner_d;
  logic          a_rvalid_q, b_rvalid_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  logic a_elig, b_elig;
  logic a_gnt, b_gnt;
  logic a_rd, b_rd;

  // The lock removes A from contention in the same cycle it is raised.
  assign a_elig = bus.a_req & ~bus.b_lock;
  assign b_elig = bus.b_req;

  // Grant selection and next owner; grants are forced low while in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    owner_d = owner_q;
    if (reset) begin
      if (a_elig && b_elig) begin
        if (owner_q == PORT_A) b_gnt = 1'b1;
        else                   a_gnt = 1'b1;
      end else if (a_elig) begin
        a_gnt = 1'b1;
      end else if (b_elig) begin
        b_gnt = 1'b1;
      end
    end
    if (a_gnt) owner_d = PORT_A;
    if (b_gnt) owner_d = PORT_B;
  end

  assign a_rd = a_gnt & ~bus.a_we;
  assign b_rd = b_gnt & ~bus.b_we;

  // Owner, read-valid pulses and held read data.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      owner_q    <= PORT_B;   // A wins the first tie after reset
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      a_rvalid_q <= a_rd;
      b_rvalid_q <= b_rd;
      if (a_rd) a_rdata_q <= mem_q[bus.a_addr];
      if (b_rd) b_rdata_q <= mem_q[bus.b_addr];
    end
  end

  // Array write port; at most one port is granted so the writes never collide.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto plain RAM; a write caught
    // by reset is dropped because the grants are already forced low.
    if (a_gnt && bus.a_we) begin
      mem_q[bus.a_addr] <= bus.a_wdata;
    end else if (b_gnt && bus.b_we) begin
      mem_q[bus.b_addr] <= bus.b_wdata;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// constrained-random traffic, all compared against a behavioural model.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.AW(5), .DW(8)) bus ();

  mem_port_arbiter #(.AW(5), .DW(8), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mem_m [32];
  int         exp_owner;
  bit         exp_arv, exp_brv;
  logic [7:0] exp_ard, exp_brd;
  bit         last_ag, last_bg;   // model grants of the last cycle
  logic       obs_ag, obs_bg;     // DUT grants of the last cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict and check grants mid-cycle, then advance the model
  // across the rising edge and check the registered outputs.
  task automatic cycle();
    bit ae, be, ag, bg;
    @(negedge clk);
    ae = bus.a_req && !bus.b_lock && reset;
    be = bus.b_req && reset;
    ag = 0;
    bg = 0;
    if (ae && be) begin
      if (exp_owner == 0) bg = 1;
      else                ag = 1;
    end else if (ae) ag = 1;
    else if (be)     bg = 1;
    obs_ag = bus.a_gnt;
    obs_bg = bus.b_gnt;
    check("a_gnt", {31'd0, obs_ag}, {31'd0, ag});
    check("b_gnt", {31'd0, obs_bg}, {31'd0, bg});
    last_ag = ag;
    last_bg = bg;
    @(posedge clk);
    #1;
    if (!reset) begin
      exp_owner = 1;
      exp_arv = 0;
      exp_brv = 0;
      exp_ard = 8'h00;
      exp_brd = 8'h00;
    end else begin
      exp_arv = ag && !bus.a_we;
      exp_brv = bg && !bus.b_we;
      if (exp_arv) exp_ard = mem_m[bus.a_addr];
      if (exp_brv) exp_brd = mem_m[bus.b_addr];
      if (ag && bus.a_we) mem_m[bus.a_addr] = bus.a_wdata;
      if (bg && bus.b_we) mem_m[bus.b_addr] = bus.b_wdata;
      if (ag) exp_owner = 0;
      if (bg) exp_owner = 1;
    end
    check("a_rvalid", {31'd0, bus.a_rvalid}, {31'd0, exp_arv});
    check("b_rvalid", {31'd0, bus.b_rvalid}, {31'd0, exp_brv});
    check("a_rdata",  {24'd0, bus.a_rdata},  {24'd0, exp_ard});
    check("b_rdata",  {24'd0, bus.b_rdata},  {24'd0, exp_brd});
    check("owner",    {31'd0, bus.owner},    exp_owner);
  endtask

  task automatic idle_ports();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  initial begin
    logic [3:0] rr_seq;
    bit a_pend, b_pend;

    reset = 1'b0;
    bus.b_lock = 1'b0;
    idle_ports();
    exp_owner = 1;
    exp_arv = 0; exp_brv = 0;
    exp_ard = 8'h00; exp_brd = 8'h00;
    for (int i = 0; i < 32; i++) mem_m[i] = 8'hxx;

    // Reset values, with a request pending to prove grants stay low
    bus.a_req = 1;
    cycle();
    cycle();
    bus.a_req = 0;
    reset = 1'b1;

    // Host load under lock: whole array, addr 0..3 = 0x11..0x14, addr 7 = 0x22
    bus.b_lock = 1;
    for (int i = 0; i < 32; i++) begin
      bus.b_req = 1;
      bus.b_we = 1;
      bus.b_addr = 5'(i);
      bus.b_wdata = (i < 4) ? 8'(8'h11 + i) : (i == 7) ? 8'h22 : 8'($urandom);
      cycle();
    end
    idle_ports();
    bus.b_lock = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'd2;
    cycle();
    check("hl_a_gnt", {31'd0, obs_ag}, 32'd1);
    idle_ports();
    check("hl_rdata", {24'd0, bus.a_rdata}, 32'h13);
    cycle();

    // Round-robin tie straight after reset
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'd5;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 5'd6;
    for (int i = 0; i < 4; i++) begin
      cycle();
      rr_seq[i] = obs_bg;
    end
    check("rr_seq", {28'd0, rr_seq}, 32'b1010);
    idle_ports();
    cycle();

    // Lock starvation: A waits six cycles, then wins as the lock drops
    bus.b_lock = 1;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'd0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("lock_a_gnt", {31'd0, obs_ag}, 32'd0);
    end
    bus.b_lock = 0;
    cycle();
    check("unlock_a_gnt", {31'd0, obs_ag}, 32'd1);
    idle_ports();

    // Write/read ordering: mem[3]=0 via B (owner=1), then A writes, B reads
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd3; bus.b_wdata = 8'h00;
    cycle();
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd3; bus.a_wdata = 8'hAB;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 5'd3;
    cycle();
    check("ord_a_first", {31'd0, obs_ag}, 32'd1);
    bus.a_req = 0;
    cycle();
    check("ord_b_next", {31'd0, obs_bg}, 32'd1);
    check("ord_b_rdata", {24'd0, bus.b_rdata}, 32'hAB);
    idle_ports();

    // Read hold: A writes 0x5A to addr 1, reads it, then idles
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd1; bus.a_wdata = 8'h5A;
    cycle();
    bus.a_we = 0;
    cycle();
    idle_ports();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_rdata", {24'd0, bus.a_rdata}, 32'h5A);
    end

    // Reset while a_rvalid=1 and during B's granted write of 0x55 to addr 7
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'd0;
    cycle();
    bus.a_req = 0;
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd7; bus.b_wdata = 8'h55;
    #2;
    reset = 1'b0;
    #1;
    check("rst_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
    check("rst_a_rdata",  {24'd0, bus.a_rdata},  32'd0);
    check("rst_owner",    {31'd0, bus.owner},    32'd1);
    check("rst_b_gnt",    {31'd0, bus.b_gnt},    32'd0);
    exp_arv = 0; exp_ard = 8'h00; exp_owner = 1;
    cycle();
    reset = 1'b1;
    bus.b_we = 0;
    cycle();
    check("rst_mem7", {24'd0, bus.b_rdata}, 32'h22);
    idle_ports();
    cycle();

    // Random traffic honouring the hold-until-granted contract
    a_pend = 0;
    b_pend = 0;
    for (int n = 0; n < 400; n++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1;
        bus.a_we = 1'($urandom_range(0, 1));
        bus.a_addr = 5'($urandom_range(0, 31));
        bus.a_wdata = 8'($urandom);
      end
      if (!b_pend && $urandom_range(0, 3) != 0) begin
        b_pend = 1;
        bus.b_we = 1'($urandom_range(0, 1));
        bus.b_addr = 5'($urandom_range(0, 31));
        bus.b_wdata = 8'($urandom);
      end
      bus.a_req = a_pend;
      bus.b_req = b_pend;
      bus.b_lock = ($urandom_range(0, 4) == 0);
      cycle();
      if (last_ag) a_pend = 0;
      if (last_bg) b_pend = 0;
    end
    idle_ports();
    bus.b_lock = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
